// File: rtl/antares_hilo_sequencer_pkg.sv
// rtl/antares_hilo_sequencer_pkg.sv - ALU op codes, FSM/accumulate encodings and op-decode helpers
package antares_hilo_sequencer_pkg;

  localparam logic [4:0] ALU_OP_ADD   = 5'd0;
  localparam logic [4:0] ALU_OP_ADDU  = 5'd1;
  localparam logic [4:0] ALU_OP_AND   = 5'd2;
  localparam logic [4:0] ALU_OP_DIV   = 5'd5;
  localparam logic [4:0] ALU_OP_DIVU  = 5'd6;
  localparam logic [4:0] ALU_OP_MFHI  = 5'd7;
  localparam logic [4:0] ALU_OP_MFLO  = 5'd8;
  localparam logic [4:0] ALU_OP_MTHI  = 5'd9;
  localparam logic [4:0] ALU_OP_MTLO  = 5'd10;
  localparam logic [4:0] ALU_OP_MULS  = 5'd11;
  localparam logic [4:0] ALU_OP_MULU  = 5'd12;
  localparam logic [4:0] ALU_OP_MADD  = 5'd13;
  localparam logic [4:0] ALU_OP_MADDU = 5'd14;
  localparam logic [4:0] ALU_OP_MSUB  = 5'd15;
  localparam logic [4:0] ALU_OP_MSUBU = 5'd16;

  typedef enum logic [1:0] {
    HILO_ST_IDLE,
    HILO_ST_MULT_WAIT,
    HILO_ST_DIV_START,
    HILO_ST_DIV_WAIT
  } hilo_state_e;

  typedef enum logic [1:0] {
    HILO_ACC_NONE,
    HILO_ACC_SET,
    HILO_ACC_ADD,
    HILO_ACC_SUB
  } hilo_acc_e;

  function automatic logic is_mult_op(input logic [4:0] op);
    return (op == ALU_OP_MULS)  || (op == ALU_OP_MULU)  ||
           (op == ALU_OP_MADD)  || (op == ALU_OP_MADDU) ||
           (op == ALU_OP_MSUB)  || (op == ALU_OP_MSUBU);
  endfunction

  function automatic logic is_mult_signed(input logic [4:0] op);
    return (op == ALU_OP_MULS) || (op == ALU_OP_MADD) || (op == ALU_OP_MSUB);
  endfunction

  function automatic hilo_acc_e mult_acc_kind(input logic [4:0] op);
    if ((op == ALU_OP_MADD) || (op == ALU_OP_MADDU)) return HILO_ACC_ADD;
    if ((op == ALU_OP_MSUB) || (op == ALU_OP_MSUBU)) return HILO_ACC_SUB;
    return HILO_ACC_SET;
  endfunction

  function automatic logic is_hilo_access(input logic [4:0] op);
    return is_mult_op(op) || (op == ALU_OP_DIV) || (op == ALU_OP_DIVU) ||
           (op == ALU_OP_MTHI) || (op == ALU_OP_MTLO) ||
           (op == ALU_OP_MFHI) || (op == ALU_OP_MFLO);
  endfunction

endpackage

// File: rtl/antares_hilo_sequencer_if.sv
// rtl/antares_hilo_sequencer_if.sv - start/done handshake between the HILO sequencer and the mult/div units
interface antares_hilo_sequencer_if;

  logic        mult_enable_op;
  logic        mult_signed_op;
  logic        mult_ready;
  logic [63:0] mult_result;
  logic        op_divs;
  logic        op_divu;
  logic        div_stall;
  logic [31:0] quotient;
  logic [31:0] remainder;

  modport master (
    output mult_enable_op, mult_signed_op, op_divs, op_divu,
    input  mult_ready, mult_result, div_stall, quotient, remainder
  );

  modport slave (
    input  mult_enable_op, mult_signed_op, op_divs, op_divu,
    output mult_ready, mult_result, div_stall, quotient, remainder
  );

endinterface

// File: rtl/antares_hilo_watchdog.sv
// rtl/antares_hilo_watchdog.sv - wait-state cycle counter; timeout flags the last allowed cycle
module antares_hilo_watchdog #(
  parameter int CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout = enable && (count_q == CW'(CYCLES - 1));

endmodule

// File: rtl/antares_hilo_sequencer.sv
// rtl/antares_hilo_sequencer.sv - owns HILO, issues mult/div starts, writes back results and stalls EX
module antares_hilo_sequencer
  import antares_hilo_sequencer_pkg::*;
#(
  parameter int ENABLE_HW_MULT  = 1,
  parameter int ENABLE_HW_DIV   = 1,
  parameter int WATCHDOG_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_alu_operation,
  input  logic [31:0] ex_alu_port_a,
  input  logic [31:0] ex_alu_port_b,
  input  logic        ex_stall,
  input  logic        ex_flush,
  antares_hilo_sequencer_if.master unit_if,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        ex_request_stall,
  output logic        hilo_busy,
  output logic        hilo_error
);

  hilo_state_e state_q, state_d;
  hilo_acc_e   kind_q, kind_d;
  logic [63:0] hilo_q, hilo_d;
  logic        wd_timeout;
  logic        issue_ok;
  logic        in_idle;

  assign in_idle  = (state_q == HILO_ST_IDLE);
  // Holding issue off while rst is low keeps every output quiet during reset.
  assign issue_ok = rst && !(ex_stall || ex_flush);

  antares_hilo_watchdog #(
    .CYCLES (WATCHDOG_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst),
    .clear   (in_idle),
    .enable  (!in_idle),
    .timeout (wd_timeout)
  );

  always_comb begin
    state_d                = state_q;
    kind_d                 = kind_q;
    hilo_d                 = hilo_q;
    unit_if.mult_enable_op = 1'b0;
    unit_if.mult_signed_op = 1'b0;
    unit_if.op_divs        = 1'b0;
    unit_if.op_divu        = 1'b0;
    hilo_error             = 1'b0;

    unique case (state_q)
      HILO_ST_IDLE: begin
        if (issue_ok) begin
          if (is_mult_op(ex_alu_operation)) begin
            if (ENABLE_HW_MULT != 0) begin
              unit_if.mult_enable_op = 1'b1;
              unit_if.mult_signed_op = is_mult_signed(ex_alu_operation);
              kind_d                 = mult_acc_kind(ex_alu_operation);
              state_d                = HILO_ST_MULT_WAIT;
            end
          end else if ((ex_alu_operation == ALU_OP_DIV) || (ex_alu_operation == ALU_OP_DIVU)) begin
            if ((ENABLE_HW_DIV != 0) && (ex_alu_port_b != 32'd0)) begin
              unit_if.op_divs = (ex_alu_operation == ALU_OP_DIV);
              unit_if.op_divu = (ex_alu_operation == ALU_OP_DIVU);
              state_d         = HILO_ST_DIV_START;
            end
          end else if (ex_alu_operation == ALU_OP_MTHI) begin
            hilo_d = {ex_alu_port_a, hilo_q[31:0]};
          end else if (ex_alu_operation == ALU_OP_MTLO) begin
            hilo_d = {hilo_q[63:32], ex_alu_port_a};
          end
        end
      end

      HILO_ST_MULT_WAIT: begin
        if (unit_if.mult_ready) begin
          unique case (kind_q)
            HILO_ACC_ADD: hilo_d = hilo_q + unit_if.mult_result;
            HILO_ACC_SUB: hilo_d = hilo_q - unit_if.mult_result;
            default:      hilo_d = unit_if.mult_result;
          endcase
          state_d = HILO_ST_IDLE;
        end else if (wd_timeout) begin
          hilo_error = 1'b1;
          state_d    = HILO_ST_IDLE;
        end
      end

      // The divider registers its start on the edge entering this state, so
      // div_stall is not trustworthy until the following cycle.
      HILO_ST_DIV_START: begin
        if (wd_timeout) begin
          hilo_error = 1'b1;
          state_d    = HILO_ST_IDLE;
        end else begin
          state_d = HILO_ST_DIV_WAIT;
        end
      end

      HILO_ST_DIV_WAIT: begin
        if (!unit_if.div_stall) begin
          hilo_d  = {unit_if.remainder, unit_if.quotient};
          state_d = HILO_ST_IDLE;
        end else if (wd_timeout) begin
          hilo_error = 1'b1;
          state_d    = HILO_ST_IDLE;
        end
      end

      default: state_d = HILO_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HILO_ST_IDLE;
      kind_q  <= HILO_ACC_NONE;
      hilo_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      hilo_q  <= hilo_d;
    end
  end

  assign hi               = hilo_q[63:32];
  assign lo               = hilo_q[31:0];
  assign hilo_busy        = !in_idle;
  assign ex_request_stall = !in_idle && is_hilo_access(ex_alu_operation);

endmodule

// File: tb/tb_antares_hilo_sequencer.sv
// tb/tb_antares_hilo_sequencer.sv - directed vector table plus multi-cycle sequences for the HILO sequencer
module tb_antares_hilo_sequencer;
  import antares_hilo_sequencer_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        ex_stall;
  logic        ex_flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        ex_request_stall;
  logic        hilo_busy;
  logic        hilo_error;

  int errors = 0;
  int checks = 0;

  antares_hilo_sequencer_if u_if ();

  antares_hilo_sequencer #(
    .ENABLE_HW_MULT  (1),
    .ENABLE_HW_DIV   (1),
    .WATCHDOG_CYCLES (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_alu_operation (op),
    .ex_alu_port_a    (a),
    .ex_alu_port_b    (b),
    .ex_stall         (ex_stall),
    .ex_flush         (ex_flush),
    .unit_if          (u_if.master),
    .hi               (hi),
    .lo               (lo),
    .ex_request_stall (ex_request_stall),
    .hilo_busy        (hilo_busy),
    .hilo_error       (hilo_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        flush;
    logic        e_mult;
    logic        e_sgn;
    logic        e_divs;
    logic        e_divu;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] o, input logic [31:0] va, input logic [31:0] vb);
    op = o;
    a  = va;
    b  = vb;
    #1;
  endtask

  initial begin
    logic found;
    int   hit;

    vecs[0]  = '{ALU_OP_MTHI,  32'hDEADBEEF, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{ALU_OP_MTHI,  32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{ALU_OP_MTLO,  32'h12345678, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[3]  = '{ALU_OP_MTLO,  32'h12345678, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h12345678};
    vecs[4]  = '{ALU_OP_DIV,   32'd5,        32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h12345678};
    vecs[5]  = '{ALU_OP_DIVU,  32'd5,        32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h12345678};
    vecs[6]  = '{ALU_OP_MFHI,  32'h0,        32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h12345678};
    vecs[7]  = '{ALU_OP_MULS,  32'd3,        32'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h12345678};
    vecs[8]  = '{ALU_OP_MADD,  32'd3,        32'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h12345678};
    vecs[9]  = '{ALU_OP_DIV,   32'd9,        32'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h12345678};
    vecs[10] = '{ALU_OP_MTHI,  32'hCAFEF00D, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 32'h12345678};

    rst = 1'b0; op = ALU_OP_ADD; a = '0; b = '0; ex_stall = 1'b0; ex_flush = 1'b0;
    u_if.mult_ready = 1'b0; u_if.mult_result = '0; u_if.div_stall = 1'b0;
    u_if.quotient = '0; u_if.remainder = '0;
    #12;
    check("reset_hilo",  {hi, lo}, 64'd0);
    check("reset_busy",  hilo_busy, 0);
    check("reset_err",   hilo_error, 0);
    check("reset_stall", ex_request_stall, 0);
    check("reset_starts", {u_if.mult_enable_op, u_if.mult_signed_op, u_if.op_divs, u_if.op_divu}, 0);
    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      ex_stall = vecs[i].stall;
      ex_flush = vecs[i].flush;
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_starts", i),
            {u_if.mult_enable_op, u_if.mult_signed_op, u_if.op_divs, u_if.op_divu},
            {vecs[i].e_mult, vecs[i].e_sgn, vecs[i].e_divs, vecs[i].e_divu});
      check($sformatf("vec%0d_req_stall", i), ex_request_stall, 0);
      tick();
      check($sformatf("vec%0d_hilo", i), {hi, lo}, {vecs[i].e_hi, vecs[i].e_lo});
      check($sformatf("vec%0d_busy", i), hilo_busy, 0);
    end
    ex_stall = 1'b0; ex_flush = 1'b0;

    // MULU with mult_ready on the third busy cycle; ex_stall rising must not stretch the pulse.
    drive(ALU_OP_MULU, 32'hFFFFFFFF, 32'd2);
    check("mulu_start", {u_if.mult_enable_op, u_if.mult_signed_op}, 2'b10);
    tick();
    ex_stall = 1'b1;
    drive(ALU_OP_ADD, 32'd0, 32'd0);
    check("mulu_pulse_len", u_if.mult_enable_op, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mulu_busy%0d", i), hilo_busy, 1);
      if (i == 2) begin
        u_if.mult_ready = 1'b1; u_if.mult_result = 64'h00000001_FFFFFFFE;
      end
      tick();
    end
    u_if.mult_ready = 1'b0; ex_stall = 1'b0;
    check("mulu_hilo", {hi, lo}, 64'h00000001_FFFFFFFE);
    check("mulu_idle", hilo_busy, 0);

    // MSUB accumulate: 0x10 - (-3) = 0x13.
    drive(ALU_OP_MTHI, 32'd0, 32'd0); tick();
    drive(ALU_OP_MTLO, 32'h10, 32'd0); tick();
    check("msub_pre", {hi, lo}, 64'h10);
    drive(ALU_OP_MSUB, 32'hFFFFFFFF, 32'd3);
    check("msub_start", {u_if.mult_enable_op, u_if.mult_signed_op}, 2'b11);
    tick();
    drive(ALU_OP_ADD, 32'd0, 32'd0);
    u_if.mult_ready = 1'b1; u_if.mult_result = 64'hFFFFFFFF_FFFFFFFD;
    tick();
    u_if.mult_ready = 1'b0;
    check("msub_hilo", {hi, lo}, 64'h13);

    // DIVU 100/7 with MFLO waiting in EX.
    drive(ALU_OP_DIVU, 32'd100, 32'd7);
    check("divu_start", {u_if.op_divs, u_if.op_divu}, 2'b01);
    tick();
    u_if.div_stall = 1'b1;
    drive(ALU_OP_MFLO, 32'd0, 32'd0);
    check("divu_pulse_len", u_if.op_divu, 0);
    check("divu_stall_start", ex_request_stall, 1);
    tick();
    check("divu_stall_wait", ex_request_stall, 1);
    tick();
    u_if.div_stall = 1'b0; u_if.quotient = 32'd14; u_if.remainder = 32'd2;
    #1;
    check("divu_stall_done", ex_request_stall, 1);
    tick();
    check("divu_stall_drop", ex_request_stall, 0);
    check("divu_hilo", {hi, lo}, {32'd2, 32'd14});

    // Watchdog: MULS with mult_ready withheld, WATCHDOG_CYCLES=8.
    drive(ALU_OP_MULS, 32'd7, 32'd7);
    tick();
    drive(ALU_OP_ADD, 32'd0, 32'd0);
    found = 1'b0; hit = -1;
    for (int i = 0; i < 20 && !found; i++) begin
      if (hilo_error) begin
        found = 1'b1; hit = i;
      end else begin
        tick();
      end
    end
    check("wd_seen", found, 1);
    check("wd_cycle", hit, 7);
    tick();
    check("wd_idle", hilo_busy, 0);
    check("wd_err_pulse", hilo_error, 0);
    check("wd_hilo", {hi, lo}, {32'd2, 32'd14});
    u_if.mult_ready = 1'b1; u_if.mult_result = 64'h1234_5678_9ABC_DEF0;
    tick();
    u_if.mult_ready = 1'b0;
    check("late_ready_hilo", {hi, lo}, {32'd2, 32'd14});
    check("late_ready_idle", hilo_busy, 0);

    // Async reset in the middle of DIV_WAIT.
    drive(ALU_OP_DIVU, 32'd9, 32'd3);
    tick();
    u_if.div_stall = 1'b1;
    drive(ALU_OP_MFLO, 32'd0, 32'd0);
    tick();
    check("rst_pre_busy", hilo_busy, 1);
    rst = 1'b0;
    #1;
    check("rst_async_hilo", {hi, lo}, 64'd0);
    check("rst_async_busy", hilo_busy, 0);
    check("rst_async_stall", ex_request_stall, 0);
    tick();
    rst = 1'b1; u_if.div_stall = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/antares_hilo_sequencer.md
Name: antares_hilo_sequencer

Overview:
- Owns the 64-bit HILO register and sequences the multi-cycle multiplier and divider units on behalf of the EX stage.
- Issues one-cycle start pulses to the units and waits for their completion.
- Performs the HILO writeback, including the MADD/MSUB accumulate.
- Raises ex_request_stall while any later HILO-accessing instruction must wait.

Parameters:
- ENABLE_HW_MULT, 1, 0 = MUL*/MADD*/MSUB* are no-ops: no start pulse, HILO unchanged.
- ENABLE_HW_DIV, 1, 0 = DIV/DIVU are no-ops.
- WATCHDOG_CYCLES, 64, maximum cycles spent in a wait state before forced abort to IDLE (must be >= 2).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- ex_alu_operation  in  5  ALU op code (ALU_OP_* from antares_defines)
- ex_alu_port_a  in  32  operand A / dividend / MTHI-MTLO data
- ex_alu_port_b  in  32  operand B / divisor
- ex_stall  in  1  EX stage stalled
- ex_flush  in  1  EX stage flushed
- mult_enable_op  out  1  one-cycle multiplier start
- mult_signed_op  out  1  signed multiply, valid with mult_enable_op
- mult_ready  in  1  multiplier result valid (one-cycle pulse)
- mult_result  in  64  multiplier product
- op_divs  out  1  one-cycle signed divide start
- op_divu  out  1  one-cycle unsigned divide start
- div_stall  in  1  divider busy
- quotient  in  32  divider quotient
- remainder  in  32  divider remainder
- hi  out  32  HILO[63:32]
- lo  out  32  HILO[31:0]
- ex_request_stall  out  1  EX must hold the current HILO-accessing op
- hilo_busy  out  1  state != IDLE
- hilo_error  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, HILO=0, watchdog=0, latched kind=NONE.
  - All outputs 0.
- enable_ex = ~(ex_stall | ex_flush).
- hilo_access = op in {DIV, DIVU, MULS, MULU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO, MFHI, MFLO}.
- ex_request_stall = (state != IDLE) & hilo_access. It is combinational, and is 0 in IDLE.
- FSM states: IDLE, MULT_WAIT, DIV_START, DIV_WAIT.
- IDLE, only when enable_ex:
  - MULS/MULU/MADD*/MSUB*: pulse mult_enable_op. mult_signed_op=1 for MULS, MADD, MSUB. Latch kind (SET/ADD/SUB). Go to MULT_WAIT.
  - DIV/DIVU with B!=0: pulse op_divs/op_divu. Go to DIV_START.
  - DIV/DIVU with B==0: no pulse, HILO unchanged, stay IDLE.
  - MTHI: HILO <= {A, lo}. MTLO: HILO <= {hi, A}. Stay IDLE.
  - MFHI/MFLO, other ops: no action. hi/lo are always driven from the register.
- MULT_WAIT, on mult_ready:
  - SET: HILO <= mult_result.
  - ADD: HILO <= HILO + mult_result.
  - SUB: HILO <= HILO - mult_result.
  - 64-bit modulo arithmetic, no flags. Then go to IDLE.
- DIV_START: one-cycle guard so div_stall is sampled only after the divider registered the start. Go to DIV_WAIT unconditionally.
- DIV_WAIT: when div_stall==0, HILO <= {remainder, quotient} and go to IDLE.
- Watchdog:
  - Counts every cycle in MULT_WAIT/DIV_START/DIV_WAIT and clears in IDLE.
  - When count reaches WATCHDOG_CYCLES-1 without completion: go to IDLE, HILO unchanged, pulse hilo_error.
- Flush/stall:
  - ex_flush and ex_stall only gate issue in IDLE.
  - An in-flight operation always completes; its instruction has already left EX.
- Completion cycle: ex_request_stall is still 1 if a HILO op waits in EX. That op issues on the next cycle (one-cycle bubble, by design).
- Start pulses last exactly one cycle, even if ex_stall rises in the following cycle.
- A late mult_ready seen in IDLE after a watchdog abort is ignored.

Decomposition:
- Shared package/defines hold:
  - ALU_OP_* codes (existing antares_defines).
  - FSM state encodings HILO_ST_IDLE/MULT_WAIT/DIV_START/DIV_WAIT.
  - Accumulate kind encodings HILO_ACC_SET/ADD/SUB.
- One natural sub-module: antares_hilo_watchdog (cycle counter with clear/enable and timeout output).
- Multiplier and divider remain external and are instantiated by the ALU.

Test Plan:
- MULU A=0xFFFFFFFF, B=2, mult_ready 3 cycles later -> 1-cycle mult_enable_op, signed=0; HILO=0x00000001_FFFFFFFE; hilo_busy high for 3 cycles.
- HILO=0x00000000_00000010, then MSUB A=-1, B=3 with product 0xFFFFFFFF_FFFFFFFD -> HILO=0x00000000_00000013.
- DIVU A=100, B=7, then MFLO in EX during DIV_WAIT -> ex_request_stall=1 until completion; then HILO={2,14}, stall drops the next cycle.
- DIV A=5, B=0 -> no op_divs pulse, HILO unchanged, ex_request_stall never asserted.
- MTHI A=0xDEADBEEF with ex_flush=1 -> HILO unchanged; same op with ex_flush=0 -> hi=0xDEADBEEF, lo preserved.
- MULS issued, mult_ready withheld, WATCHDOG_CYCLES=8 -> after 8 cycles hilo_error pulses, state IDLE, HILO unchanged; rst asserted mid-DIV_WAIT -> HILO=0 and outputs 0 immediately (async).
